// File: rtl/umips_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : umips_pipe_stage
// Brief    : Parametrised inter-stage pipeline register for the umips core.
//            Carries data and control payloads with valid/ready handshake,
//            an optional one-entry skid buffer, flush and a stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module umips_pipe_stage #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Main register M drives the outputs; skid register S holds overflow.
    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data, s_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic [1:0]        level_q;
    logic [CNT_W-1:0]  stall_q;

    logic              m_valid_n, s_valid_n;
    logic [DATA_W-1:0] m_data_n, s_data_n;
    logic [CTRL_W-1:0] m_ctrl_n, s_ctrl_n;
    logic [1:0]        level_n;

    logic in_fire;
    logic out_fire;

    // With a skid buffer, in_ready comes straight from a flop; otherwise it
    // looks through to the downstream ready.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = ~s_valid;
        end else begin : g_noskid
            assign in_ready = ~m_valid | out_ready;
        end
    endgenerate

    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid & out_ready;

    // Next-state for M and S; any slot that goes invalid is loaded with zeros
    // so the outputs show a clean bubble without output gating.
    always_comb begin
        m_valid_n = m_valid;
        m_data_n  = m_data;
        m_ctrl_n  = m_ctrl;
        s_valid_n = s_valid;
        s_data_n  = s_data;
        s_ctrl_n  = s_ctrl;
        if (flush) begin
            m_valid_n = 1'b0;
            m_data_n  = '0;
            m_ctrl_n  = '0;
            s_valid_n = 1'b0;
            s_data_n  = '0;
            s_ctrl_n  = '0;
        end else if (SKID != 0) begin
            case ({m_valid, s_valid})
                2'b00: begin
                    if (in_fire) begin
                        m_valid_n = 1'b1;
                        m_data_n  = in_data;
                        m_ctrl_n  = in_ctrl;
                    end
                end
                2'b10: begin
                    if (in_fire && out_fire) begin
                        m_data_n = in_data;
                        m_ctrl_n = in_ctrl;
                    end else if (in_fire) begin
                        s_valid_n = 1'b1;
                        s_data_n  = in_data;
                        s_ctrl_n  = in_ctrl;
                    end else if (out_fire) begin
                        m_valid_n = 1'b0;
                        m_data_n  = '0;
                        m_ctrl_n  = '0;
                    end
                end
                2'b11: begin
                    if (out_fire) begin
                        m_data_n  = s_data;
                        m_ctrl_n  = s_ctrl;
                        s_valid_n = 1'b0;
                        s_data_n  = '0;
                        s_ctrl_n  = '0;
                    end
                end
                default: begin
                    // S-only is unreachable; hold.
                end
            endcase
        end else begin
            if (in_fire) begin
                m_valid_n = 1'b1;
                m_data_n  = in_data;
                m_ctrl_n  = in_ctrl;
            end else if (out_fire) begin
                m_valid_n = 1'b0;
                m_data_n  = '0;
                m_ctrl_n  = '0;
            end
        end
        level_n = {1'b0, m_valid_n} + {1'b0, s_valid_n};
    end

    // Entry registers and occupancy level.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= '0;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_ctrl  <= '0;
            level_q <= 2'd0;
        end else begin
            m_valid <= m_valid_n;
            m_data  <= m_data_n;
            m_ctrl  <= m_ctrl_n;
            s_valid <= s_valid_n;
            s_data  <= s_data_n;
            s_ctrl  <= s_ctrl_n;
            level_q <= level_n;
        end
    end

    // Saturating count of cycles the head entry waits on downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (m_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_ctrl;
    assign level     = level_q;
    assign stall_cnt = stall_q;

endmodule
`default_nettype wire

// File: tb/tb_umips_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_umips_pipe_stage
// Brief    : Directed self-checking bench for umips_pipe_stage. Three
//            instances share stimulus: default (SKID=1), CNT_W=4, SKID=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_umips_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic [15:0] in_ctrl;
    logic        out_ready;

    logic        a_in_ready, a_out_valid;
    logic [63:0] a_out_data;
    logic [15:0] a_out_ctrl;
    logic [1:0]  a_level;
    logic [15:0] a_stall;

    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_data;
    logic [15:0] b_out_ctrl;
    logic [1:0]  b_level;
    logic [3:0]  b_stall;

    logic        c_in_ready, c_out_valid;
    logic [63:0] c_out_data;
    logic [15:0] c_out_ctrl;
    logic [1:0]  c_level;
    logic [15:0] c_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    umips_pipe_stage #(.DATA_W(64), .CTRL_W(16), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(a_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_ctrl(a_out_ctrl), .level(a_level), .stall_cnt(a_stall)
    );

    umips_pipe_stage #(.DATA_W(64), .CTRL_W(16), .SKID(1), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(b_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_ctrl(b_out_ctrl), .level(b_level), .stall_cnt(b_stall)
    );

    umips_pipe_stage #(.DATA_W(64), .CTRL_W(16), .SKID(0), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .in_ready(c_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .out_ctrl(c_out_ctrl), .level(c_level), .stall_cnt(c_stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an entry; control payload is derived so it is nonzero and distinct.
    task automatic offer(input logic [63:0] d);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = d[15:0] ^ 16'h8000;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        check("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
        check("rst_out_data", a_out_data, 64'd0);
        check("rst_out_ctrl", {48'd0, a_out_ctrl}, 64'd0);
        check("rst_level", {62'd0, a_level}, 64'd0);
        check("rst_stall", {48'd0, a_stall}, 64'd0);
        check("rst_in_ready", {63'd0, a_in_ready}, 64'd1);

        // Back-to-back stream
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            offer(64'(i));
            tick();
            check("stream_data", a_out_data, 64'(i));
            check("stream_ctrl", {48'd0, a_out_ctrl}, {48'd0, 16'(i) ^ 16'h8000});
            check("stream_level", {62'd0, a_level}, 64'd1);
            check("stream_in_ready", {63'd0, a_in_ready}, 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("drain_valid", {63'd0, a_out_valid}, 64'd0);
        check("drain_data", a_out_data, 64'd0);
        check("drain_ctrl", {48'd0, a_out_ctrl}, 64'd0);
        check("drain_level", {62'd0, a_level}, 64'd0);

        // Backpressure fill
        out_ready = 1'b0;
        offer(64'hA); tick();
        offer(64'hB); tick();
        check("fill_level", {62'd0, a_level}, 64'd2);
        check("fill_in_ready", {63'd0, a_in_ready}, 64'd0);
        check("fill_stall", {48'd0, a_stall}, 64'd1);
        offer(64'hC);
        repeat (5) tick();
        check("hold_stall", {48'd0, a_stall}, 64'd6);
        check("hold_level", {62'd0, a_level}, 64'd2);
        check("hold_head", a_out_data, 64'hA);
        out_ready = 1'b1;
        tick();
        check("bp_out1", a_out_data, 64'hB);
        check("bp_level1", {62'd0, a_level}, 64'd1);
        check("bp_in_ready1", {63'd0, a_in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_out2", a_out_data, 64'hC);
        tick();
        check("bp_empty", {63'd0, a_out_valid}, 64'd0);

        // Flush mid-stream with a concurrent offer
        out_ready = 1'b0;
        offer(64'h10); tick();
        offer(64'h11); tick();
        check("fl_level_pre", {62'd0, a_level}, 64'd2);
        offer(64'h12);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_valid", {63'd0, a_out_valid}, 64'd0);
        check("fl_ctrl", {48'd0, a_out_ctrl}, 64'd0);
        check("fl_data", a_out_data, 64'd0);
        check("fl_level", {62'd0, a_level}, 64'd0);
        check("fl_in_ready", {63'd0, a_in_ready}, 64'd1);
        check("fl_stall_kept", {48'd0, a_stall}, 64'd8);
        tick();
        check("fl_no_ghost", {63'd0, a_out_valid}, 64'd0);

        // Simultaneous in_fire and out_fire, then again with flush
        out_ready = 1'b1;
        offer(64'h20); tick();
        check("sim_head", a_out_data, 64'h20);
        offer(64'h21); tick();
        check("sim_data", a_out_data, 64'h21);
        check("sim_level", {62'd0, a_level}, 64'd1);
        offer(64'h22);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("simfl_level", {62'd0, a_level}, 64'd0);
        check("simfl_valid", {63'd0, a_out_valid}, 64'd0);

        // Saturation of the 4-bit counter
        out_ready = 1'b0;
        offer(64'h40); tick();
        in_valid = 1'b0;
        repeat (20) tick();
        check("sat_b", {60'd0, b_stall}, 64'd15);
        check("sat_a", {48'd0, a_stall}, 64'd28);
        flush = 1'b1; tick(); flush = 1'b0;
        check("sat_b_flush", {60'd0, b_stall}, 64'd15);
        check("sat_a_flush", {48'd0, a_stall}, 64'd29);
        rst = 1'b1; tick(); rst = 1'b0;
        check("sat_b_rst", {60'd0, b_stall}, 64'd0);
        check("sat_a_rst", {48'd0, a_stall}, 64'd0);

        // SKID=0 instance: combinational in_ready
        out_ready = 1'b0;
        offer(64'h30); tick();
        check("s0_head", c_out_data, 64'h30);
        check("s0_in_ready_lo", {63'd0, c_in_ready}, 64'd0);
        offer(64'h31); tick();
        check("s0_hold", c_out_data, 64'h30);
        check("s0_level_max", {62'd0, c_level}, 64'd1);
        out_ready = 1'b1;
        #1;
        check("s0_in_ready_hi", {63'd0, c_in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("s0_replace", c_out_data, 64'h31);
        check("s0_level", {62'd0, c_level}, 64'd1);
        tick();
        check("s0_empty", {63'd0, c_out_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/umips_pipe_stage.md
Name: umips_pipe_stage

Overview:
- Generic parametrised inter-stage pipeline register for the umips core. Supersedes the hand-written fixed-field stage registers.
- Carries a packed data bus and a packed control bus between two stages using a valid/ready handshake.
- Optionally includes a one-entry skid buffer so the upstream ready is registered (no combinational ready path).
- Supports flush (bubble insertion that kills in-flight entries) and a saturating stall-cycle counter for performance bring-up.

Parameters:
DATA_W, 64, width of data payload (operands, immediates, pc+4, instruction word)
CTRL_W, 16, width of control payload (reg_write, mem_write, alu_op, ...); forced to zero on bubbles
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of stall counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
flush  in  1  kill all held entries and the entry offered this cycle
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
in_data  in  DATA_W  upstream data payload
in_ctrl  in  CTRL_W  upstream control payload
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts the entry this cycle
out_data  out  DATA_W  data payload of head entry
out_ctrl  out  CTRL_W  control payload of head entry; all-zero when out_valid=0
level  out  2  entries held (0..2; max 1 when SKID=0)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Main register M drives the outputs; skid register S holds the overflow entry (SKID=1 only).
- Reset (rst=1 at clk edge): M and S invalid; out_valid=0; out_data=0; out_ctrl=0; level=0; stall_cnt=0; in_ready=1 on the cycle after reset.
- SKID=1, state = (M valid, S valid):
  - EMPTY: in_ready=1. in_fire -> ONE, M<=in. Output latency is 1 cycle.
  - ONE: in_ready=1.
    - in_fire & out_fire -> ONE, M<=in.
    - in_fire & !out_fire -> FULL, S<=in.
    - out_fire only -> EMPTY.
    - neither -> hold.
  - FULL: in_ready=0. out_fire -> ONE, M<=S. Otherwise hold, with M and S unchanged.
  - in_ready is a register output: in_ready = !S_valid.
- SKID=0: in_ready = !M_valid | out_ready (combinational). in_fire loads M. out_fire without in_fire empties M.
- Ordering: strict FIFO. Entries never duplicated or dropped, except by flush.
- Bubble rule: whenever M is invalid, out_data=0 and out_ctrl=0, registered rather than gated. A draining transition to EMPTY writes zeros.
- Flush, at the clock edge:
  - M and S are invalidated and their data/ctrl zeroed.
  - The entry offered by in_fire in that cycle is discarded.
  - An out_fire in the same cycle counts as delivered.
  - level=0 the next cycle.
  - in_ready=1 the next cycle (SKID=1).
- Priority: rst > flush > normal transfers.
- Simultaneous flush & rst: reset result.
- stall_cnt:
  - Increments each cycle with out_valid & !out_ready.
  - Holds at 2^CNT_W-1.
  - Unaffected by flush; cleared only by rst.
- level = M_valid + S_valid, registered, consistent with out_valid and in_ready in the same cycle.
- Data and ctrl are not interpreted; no width conversion. All registers update only on rising clk.

Test Plan:
- Reset, then stream: rst=1 two cycles, release; in_valid=1, in_data=1,2,3,..., out_ready=1 -> out_data=1 one cycle after first in_fire, then 2,3,... back-to-back; level=1 throughout; in_ready=1.
- Backpressure fill (SKID=1): push in_data=0xA, then 0xB, with out_ready=0 -> level=2 and in_ready=0 after 0xB. Hold 5 cycles: stall_cnt increases by 5 and 0xC is not accepted. Raise out_ready -> 0xA, 0xB, 0xC delivered in order, none lost.
- Flush mid-stream: level=2 holding 0x10, 0x11; assert flush with in_valid=1, in_data=0x12 -> next cycle out_valid=0, out_ctrl=0, out_data=0, level=0, in_ready=1; 0x12 never appears at the output.
- Simultaneous events: level=1 (M=0x20), in_fire 0x21 and out_fire in the same cycle -> level stays 1 and out_data=0x21. Repeat with flush also high -> 0x20 counted delivered, level=0.
- Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds. Flush does not clear it; rst clears it to 0.
- SKID=0 build: out_ready=0 with M valid -> in_ready=0 in the same cycle. Raising out_ready combinationally sets in_ready=1, and the new entry replaces M at the next edge.
